// File: rtl/atm_port_ctrl_if.sv
// Z80 bus as seen by the ATM port controller: address, data, control strobes
// and the fclk-domain Z80 clock edge pulses.
interface atm_port_ctrl_if;
    logic [15:0] za;
    logic [7:0]  zd;
    logic        iorq_n;
    logic        wr_n;
    logic        m1_n;
    logic        zpos;
    logic        zneg;

    modport master (output za, zd, iorq_n, wr_n, m1_n, zpos, zneg);
    modport slave  (input  za, zd, iorq_n, wr_n, m1_n, zpos, zneg);
endinterface

// File: rtl/atm_port_ctrl.sv
// ATM / pent1m I/O port controller: catches each Z80 I/O write once, decodes
// 7FFD / EFF7 / xx77 / xxF7, holds the paging config and the global DOS flag.
module atm_port_ctrl (
    input  logic                  fclk,
    input  logic                  rst_n,
    atm_port_ctrl_if.slave        zbus,
    input  logic [3:0]            dos_turn_on,
    input  logic [3:0]            dos_turn_off,
    output logic                  atm_xxF7_wr,
    output logic [5:0]            pent1m_page,
    output logic                  pent1m_ROM,
    output logic                  pent1m_ram0_0,
    output logic                  pent1m_1m_on,
    output logic                  pager_off,
    output logic                  lock_7ffd,
    output logic                  dos
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } io_state_e;

    io_state_e   r_state;
    io_state_e   w_state_nxt;
    logic        w_qualify;
    logic        w_stb;

    logic        w_dec_f7;
    logic        w_dec_eff7;
    logic        w_dec_77;
    logic        w_dec_7ffd;
    logic        w_7ffd_locked;

    logic [5:0]  r_page;
    logic        r_rom;
    logic        r_ram0_0;
    logic        r_1m_on;
    logic        r_pager_off;
    logic        r_lock;
    logic        r_dos;

    // zneg is reserved on the bus but plays no part in decoding.
    logic        w_unused;
    assign w_unused = zbus.zneg;

    assign w_qualify = ~zbus.iorq_n & ~zbus.wr_n & zbus.m1_n;

    // S_DONE marks "this I/O cycle already strobed"; only iorq_n high re-arms.
    always_ff @(posedge fclk) begin
        if (!rst_n) r_state <= S_DONE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stb       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst_n && zbus.zpos && w_qualify) begin
                    w_stb       = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (zbus.iorq_n) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_DONE;
        endcase
    end

    assign w_dec_f7   = (zbus.za[7:0] == 8'hF7) && (zbus.za[13:12] == 2'b11) &&
                        (zbus.za[10:8] == 3'b111);
    assign w_dec_eff7 = (zbus.za == 16'hEFF7);
    assign w_dec_77   = (zbus.za[7:0] == 8'h77);
    assign w_dec_7ffd = ~zbus.za[15] & ~zbus.za[1] & ~w_dec_f7 & ~w_dec_eff7 & ~w_dec_77;

    assign w_7ffd_locked = r_lock & ~r_1m_on;

    // Pagers latch their own xxF7 registers from the live bus in this cycle.
    assign atm_xxF7_wr = w_stb & w_dec_f7 & ~r_pager_off;

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_page      <= 6'd0;
            r_rom       <= 1'b0;
            r_ram0_0    <= 1'b0;
            r_1m_on     <= 1'b1;
            r_pager_off <= 1'b0;
            r_lock      <= 1'b0;
        end else if (w_stb) begin
            if (w_dec_eff7) begin
                r_1m_on  <= ~zbus.zd[2];
                r_ram0_0 <= zbus.zd[3];
            end else if (w_dec_77) begin
                r_pager_off <= ~zbus.za[8];
            end else if (w_dec_7ffd && !w_7ffd_locked) begin
                r_rom <= zbus.zd[4];
                if (r_1m_on) begin
                    r_page <= {zbus.zd[7], zbus.zd[6], zbus.zd[5], zbus.zd[2:0]};
                end else begin
                    r_page <= {3'b000, zbus.zd[2:0]};
                    r_lock <= zbus.zd[5];
                end
            end
        end
    end

    // Turn-on wins when both request kinds arrive in the same fclk.
    always_ff @(posedge fclk) begin
        if (!rst_n)                r_dos <= 1'b0;
        else if (|dos_turn_on)     r_dos <= 1'b1;
        else if (|dos_turn_off)    r_dos <= 1'b0;
    end

    assign pent1m_page   = r_page;
    assign pent1m_ROM    = r_rom;
    assign pent1m_ram0_0 = r_ram0_0;
    assign pent1m_1m_on  = r_1m_on;
    assign pager_off     = r_pager_off;
    assign lock_7ffd     = r_lock;
    assign dos           = r_dos;

endmodule

// File: tb/tb_atm_port_ctrl.sv
// Directed bench for atm_port_ctrl: Z80 OUT cycles, decode, lock, strobe,
// stretched cycles, DOS flag and reset in the middle of a write.
module tb_atm_port_ctrl;

    logic        fclk;
    logic        rst_n;
    logic [3:0]  dos_turn_on;
    logic [3:0]  dos_turn_off;
    logic        atm_xxF7_wr;
    logic [5:0]  pent1m_page;
    logic        pent1m_ROM;
    logic        pent1m_ram0_0;
    logic        pent1m_1m_on;
    logic        pager_off;
    logic        lock_7ffd;
    logic        dos;

    int total = 0;
    int bad   = 0;

    int          stb_cnt = 0;
    logic [15:0] stb_za  = 16'h0;
    logic [7:0]  stb_zd  = 8'h0;
    int          base;

    atm_port_ctrl_if bus ();

    atm_port_ctrl dut (
        .fclk          (fclk),
        .rst_n         (rst_n),
        .zbus          (bus.slave),
        .dos_turn_on   (dos_turn_on),
        .dos_turn_off  (dos_turn_off),
        .atm_xxF7_wr   (atm_xxF7_wr),
        .pent1m_page   (pent1m_page),
        .pent1m_ROM    (pent1m_ROM),
        .pent1m_ram0_0 (pent1m_ram0_0),
        .pent1m_1m_on  (pent1m_1m_on),
        .pager_off     (pager_off),
        .lock_7ffd     (lock_7ffd),
        .dos           (dos)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Strobe monitor: counts high fclk cycles and records the bus seen with them.
    always @(negedge fclk) begin
        if (atm_xxF7_wr === 1'b1) begin
            stb_cnt = stb_cnt + 1;
            stb_za  = bus.za;
            stb_zd  = bus.zd;
        end
    end

    task automatic tick;
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_zpos;
        repeat (3) tick;
        bus.zpos = 1'b1;
        tick;
        bus.zpos = 1'b0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int npos);
        bus.za = a;
        bus.zd = d;
        tick;
        bus.iorq_n = 1'b0;
        bus.wr_n   = 1'b0;
        repeat (npos) pulse_zpos;
        repeat (2) tick;
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        repeat (2) tick;
    endtask

    initial begin
        rst_n        = 1'b0;
        dos_turn_on  = 4'h0;
        dos_turn_off = 4'h0;
        bus.za       = 16'h0;
        bus.zd       = 8'h0;
        bus.iorq_n   = 1'b1;
        bus.wr_n     = 1'b1;
        bus.m1_n     = 1'b1;
        bus.zpos     = 1'b0;
        bus.zneg     = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;

        chk("rst_page",  16'(pent1m_page),   16'h0);
        chk("rst_rom",   16'(pent1m_ROM),    16'h0);
        chk("rst_ram0",  16'(pent1m_ram0_0), 16'h0);
        chk("rst_1m",    16'(pent1m_1m_on),  16'h1);
        chk("rst_poff",  16'(pager_off),     16'h0);
        chk("rst_lock",  16'(lock_7ffd),     16'h0);
        chk("rst_dos",   16'(dos),           16'h0);
        chk("rst_f7wr",  16'(atm_xxF7_wr),   16'h0);

        // 1m on: page = {d7,d6,d5,d2:0}
        base = stb_cnt;
        io_write(16'h7FFD, 8'h17, 1);
        chk("p17_page", 16'(pent1m_page), 16'h07);
        chk("p17_rom",  16'(pent1m_ROM),  16'h1);
        chk("p17_lock", 16'(lock_7ffd),   16'h0);
        chk("p17_f7",   16'(stb_cnt - base), 16'h0);

        io_write(16'h7FFD, 8'h20, 1);
        chk("p20_page", 16'(pent1m_page), 16'h08);
        chk("p20_rom",  16'(pent1m_ROM),  16'h0);
        io_write(16'h7FFD, 8'hC5, 1);
        chk("pC5_page", 16'(pent1m_page), 16'h35);
        io_write(16'h7FFD, 8'h13, 1);
        chk("p13_page", 16'(pent1m_page), 16'h03);
        chk("p13_rom",  16'(pent1m_ROM),  16'h1);

        // EFF7: d2 -> 1m off, d3 -> ram0 at 0000
        io_write(16'hEFF7, 8'h0C, 1);
        chk("eff7_1m",   16'(pent1m_1m_on),  16'h0);
        chk("eff7_ram0", 16'(pent1m_ram0_0), 16'h1);

        // 1m off: page = {000,d2:0}, lock from d5
        io_write(16'h7FFD, 8'h20, 1);
        chk("lk_page", 16'(pent1m_page), 16'h00);
        chk("lk_rom",  16'(pent1m_ROM),  16'h0);
        chk("lk_lock", 16'(lock_7ffd),   16'h1);
        io_write(16'h7FFD, 8'h17, 1);
        chk("ign_page", 16'(pent1m_page), 16'h00);
        chk("ign_rom",  16'(pent1m_ROM),  16'h0);

        // Lock is bypassed once 1m is back on, and lock bit stays put
        io_write(16'hEFF7, 8'h00, 1);
        chk("eff7b_1m", 16'(pent1m_1m_on), 16'h1);
        io_write(16'h7FFD, 8'h12, 1);
        chk("byp_page", 16'(pent1m_page), 16'h02);
        chk("byp_rom",  16'(pent1m_ROM),  16'h1);
        chk("byp_lock", 16'(lock_7ffd),   16'h1);

        // a1=1 or a15=1 must not hit 7FFD
        io_write(16'h7FFF, 8'h05, 1);
        chk("a1_page", 16'(pent1m_page), 16'h02);
        io_write(16'hFFFD, 8'h05, 1);
        chk("a15_page", 16'(pent1m_page), 16'h02);

        // xxF7 strobe: single fclk with live address/data
        base = stb_cnt;
        io_write(16'h7FF7, 8'h55, 1);
        chk("f7_cnt",  16'(stb_cnt - base), 16'h1);
        chk("f7_za",   stb_za,              16'h7FF7);
        chk("f7_zd",   16'(stb_zd),         16'h55);
        chk("f7_page", 16'(pent1m_page),    16'h02);
        io_write(16'h37F7, 8'h01, 1);
        chk("f7_37", 16'(stb_cnt - base), 16'h2);
        io_write(16'h7BF7, 8'h01, 1);
        chk("f7_7B", 16'(stb_cnt - base), 16'h2);

        // xx77 with a8=0 disables paging and suppresses the strobe
        io_write(16'h0077, 8'h00, 1);
        chk("poff_on", 16'(pager_off), 16'h1);
        base = stb_cnt;
        io_write(16'h7FF7, 8'h55, 1);
        chk("poff_nostb", 16'(stb_cnt - base), 16'h0);
        io_write(16'h0177, 8'h00, 1);
        chk("poff_off", 16'(pager_off), 16'h0);

        // Stretched cycle: four zpos samples in one I/O cycle
        base = stb_cnt;
        io_write(16'hFFF7, 8'hAA, 4);
        chk("str_one", 16'(stb_cnt - base), 16'h1);
        io_write(16'hFFF7, 8'hAB, 4);
        chk("str_two", 16'(stb_cnt - base), 16'h2);

        // DOS: on dominates off, then off alone
        dos_turn_on  = 4'b0001;
        dos_turn_off = 4'b0010;
        tick;
        dos_turn_on  = 4'b0000;
        dos_turn_off = 4'b0000;
        chk("dos_on", 16'(dos), 16'h1);
        dos_turn_off = 4'b0100;
        chk("dos_hold", 16'(dos), 16'h1);
        tick;
        dos_turn_off = 4'b0000;
        chk("dos_off", 16'(dos), 16'h0);

        // Reset mid-write
        dos_turn_on = 4'b1000;
        tick;
        dos_turn_on = 4'b0000;
        base = stb_cnt;
        bus.za     = 16'h7FF7;
        bus.zd     = 8'h11;
        bus.iorq_n = 1'b0;
        bus.wr_n   = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("mr_page", 16'(pent1m_page),  16'h0);
        chk("mr_rom",  16'(pent1m_ROM),   16'h0);
        chk("mr_lock", 16'(lock_7ffd),    16'h0);
        chk("mr_1m",   16'(pent1m_1m_on), 16'h1);
        chk("mr_dos",  16'(dos),          16'h0);
        pulse_zpos;
        pulse_zpos;
        chk("mr_nostb", 16'(stb_cnt - base), 16'h0);
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        tick;
        io_write(16'h7FF7, 8'h11, 1);
        chk("mr_newstb", 16'(stb_cnt - base), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
